// File: rtl/sprite_shifter.sv
// sprite_shifter: per-scanline sprite pixel stage.
// Latches up to NSLOTS sprites during the fetch phase, then on each active
// dot counts down X, shifts out pattern bits, resolves slot priority
// (lowest index wins) and registers one sprite pixel.
// Ports:
//   clk, rst (sync, active-low), ena (dot enable)
//   clr_slots, slot, load_attr/load_lo/load_hi, x_i, palette_i, pri_i,
//   flip_x_i, sp0_i, data_i : slot load interface
//   active    : visible-dot strobe
//   pix_color, pix_opaque, pix_pri, pix_sp0 : registered winning pixel
module sprite_shifter #(
   parameter int unsigned NSLOTS = 8,
   parameter int unsigned SLOTW  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clr_slots,
   input  logic [SLOTW-1:0] slot,
   input  logic             load_attr,
   input  logic             load_lo,
   input  logic             load_hi,
   input  logic [7:0]       x_i,
   input  logic [1:0]       palette_i,
   input  logic             pri_i,
   input  logic             flip_x_i,
   input  logic             sp0_i,
   input  logic [7:0]       data_i,
   input  logic             active,
   output logic [3:0]       pix_color,
   output logic             pix_opaque,
   output logic             pix_pri,
   output logic             pix_sp0
);

   localparam int unsigned COLW = 4;

   logic [NSLOTS-1:0]           cand;
   logic [NSLOTS-1:0][COLW-1:0] cand_col;
   logic [NSLOTS-1:0]           cand_pri;
   logic [NSLOTS-1:0]           cand_sp0;

   for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
      logic [7:0] xcnt;
      logic [1:0] pal;
      logic       pri;
      logic       flip;
      logic       sp0;
      logic [7:0] sh_lo;
      logic [7:0] sh_hi;

      logic       hit;
      logic       hit_attr;
      logic       hit_any;
      logic       flip_eff;
      logic [7:0] pat;
      logic       do_shift;

      // Slot addressing; indices outside 0..NSLOTS-1 match nothing.
      assign hit      = (slot == SLOTW'(g));
      assign hit_attr = hit & load_attr;
      assign hit_any  = hit & (load_attr | load_lo | load_hi);
      // A same-edge attribute load supplies the flip used for the pattern.
      assign flip_eff = hit_attr ? flip_x_i : flip;
      assign pat      = flip_eff ? {data_i[0], data_i[1], data_i[2], data_i[3],
                                    data_i[4], data_i[5], data_i[6], data_i[7]}
                                 : data_i;
      assign do_shift = active & ~hit_any & (xcnt == 8'd0);

      // Slot state: loads beat clear, clear beats shifting.
      always_ff @(posedge clk) begin
         if (!rst) begin
            xcnt  <= 8'd0;
            pal   <= 2'd0;
            pri   <= 1'b0;
            flip  <= 1'b0;
            sp0   <= 1'b0;
            sh_lo <= 8'd0;
            sh_hi <= 8'd0;
         end else if (ena) begin
            if (hit_attr) begin
               xcnt <= x_i;
               pal  <= palette_i;
               pri  <= pri_i;
               flip <= flip_x_i;
               sp0  <= sp0_i;
            end else begin
               if (clr_slots) sp0 <= 1'b0;
               if (active && !hit_any && xcnt != 8'd0) xcnt <= xcnt - 8'd1;
            end

            if (hit && load_lo)  sh_lo <= pat;
            else if (clr_slots)  sh_lo <= 8'd0;
            else if (do_shift)   sh_lo <= {sh_lo[6:0], 1'b0};

            if (hit && load_hi)  sh_hi <= pat;
            else if (clr_slots)  sh_hi <= 8'd0;
            else if (do_shift)   sh_hi <= {sh_hi[6:0], 1'b0};
         end
      end

      assign cand[g]     = (xcnt == 8'd0) & (sh_hi[7] | sh_lo[7]);
      assign cand_col[g] = {pal, sh_hi[7], sh_lo[7]};
      assign cand_pri[g] = pri;
      assign cand_sp0[g] = sp0;
   end

   logic [COLW-1:0] win_col;
   logic            win_vld;
   logic            win_pri;
   logic            win_sp0;

   // Lowest-index candidate wins: scan downward so the last hit is lowest.
   always_comb begin
      win_col = '0;
      win_vld = 1'b0;
      win_pri = 1'b0;
      win_sp0 = 1'b0;
      for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_col = cand_col[i];
            win_vld = 1'b1;
            win_pri = cand_pri[i];
            win_sp0 = cand_sp0[i];
         end
      end
   end

   // Output pixel register; inactive dots and transparent pixels give 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pix_color  <= '0;
         pix_opaque <= 1'b0;
         pix_pri    <= 1'b0;
         pix_sp0    <= 1'b0;
      end else if (ena) begin
         if (active && win_vld) begin
            pix_color  <= win_col;
            pix_opaque <= 1'b1;
            pix_pri    <= win_pri;
            pix_sp0    <= win_sp0;
         end else begin
            pix_color  <= '0;
            pix_opaque <= 1'b0;
            pix_pri    <= 1'b0;
            pix_sp0    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sprite_shifter.sv
// Directed bench for sprite_shifter; every edge-driven step is followed by
// checks of the registered pixel outputs one time unit after the edge.
module tb_sprite_shifter;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       clr_slots;
   logic [2:0] slot;
   logic       load_attr;
   logic       load_lo;
   logic       load_hi;
   logic [7:0] x_i;
   logic [1:0] palette_i;
   logic       pri_i;
   logic       flip_x_i;
   logic       sp0_i;
   logic [7:0] data_i;
   logic       active;
   logic [3:0] pix_color;
   logic       pix_opaque;
   logic       pix_pri;
   logic       pix_sp0;

   int checks = 0;
   int errors = 0;

   sprite_shifter #(.NSLOTS(8), .SLOTW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .clr_slots  (clr_slots),
      .slot       (slot),
      .load_attr  (load_attr),
      .load_lo    (load_lo),
      .load_hi    (load_hi),
      .x_i        (x_i),
      .palette_i  (palette_i),
      .pri_i      (pri_i),
      .flip_x_i   (flip_x_i),
      .sp0_i      (sp0_i),
      .data_i     (data_i),
      .active     (active),
      .pix_color  (pix_color),
      .pix_opaque (pix_opaque),
      .pix_pri    (pix_pri),
      .pix_sp0    (pix_sp0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pix(input string tag, input logic [3:0] col, input logic op,
                          input logic pr, input logic s0);
      chk({tag, " color"},  8'(pix_color),  8'(col));
      chk({tag, " opaque"}, 8'(pix_opaque), 8'(op));
      chk({tag, " pri"},    8'(pix_pri),    8'(pr));
      chk({tag, " sp0"},    8'(pix_sp0),    8'(s0));
   endtask

   // One active dot, then check the pixel registered for it.
   task automatic dot(input string tag, input logic [3:0] col, input logic op,
                      input logic pr, input logic s0);
      active = 1'b1;
      tick();
      active = 1'b0;
      chk_pix(tag, col, op, pr, s0);
   endtask

   task automatic clear();
      clr_slots = 1'b1;
      tick();
      clr_slots = 1'b0;
   endtask

   // Attribute + plane-0 load on one edge, plane-1 load on the next.
   task automatic load(input logic [2:0] s, input logic [7:0] x, input logic [1:0] pal,
                       input logic pr, input logic fl, input logic s0,
                       input logic [7:0] lo, input logic [7:0] hi);
      slot = s; x_i = x; palette_i = pal; pri_i = pr; flip_x_i = fl; sp0_i = s0;
      load_attr = 1'b1; load_lo = 1'b1; data_i = lo;
      tick();
      load_attr = 1'b0; load_lo = 1'b0; load_hi = 1'b1; data_i = hi;
      tick();
      load_hi = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ena = 1'b1; clr_slots = 1'b0; slot = 3'd0;
      load_attr = 1'b0; load_lo = 1'b0; load_hi = 1'b0;
      x_i = 8'd0; palette_i = 2'd0; pri_i = 1'b0; flip_x_i = 1'b0; sp0_i = 1'b0;
      data_i = 8'd0; active = 1'b0;
      tick();
      tick();
      chk_pix("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;

      // No sprites loaded.
      for (int i = 0; i < 8; i++) dot("empty", 4'h0, 1'b0, 1'b0, 1'b0);

      // Single left pixel at x=0, palette 2.
      clear();
      load(3'd0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00);
      dot("x0 dot1", 4'h9, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i <= 8; i++) dot("x0 tail", 4'h0, 1'b0, 1'b0, 1'b0);

      // Flipped pattern at x=3: bit 0 becomes leftmost.
      clear();
      load(3'd1, 8'd3, 2'd1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
      for (int i = 1; i <= 3; i++) dot("x3 lead", 4'h0, 1'b0, 1'b0, 1'b0);
      dot("x3 dot4", 4'h7, 1'b1, 1'b0, 1'b0);
      for (int i = 5; i <= 11; i++) dot("x3 tail", 4'h0, 1'b0, 1'b0, 1'b0);

      // Overlap: slot 0 beats slot 2.
      clear();
      load(3'd0, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00);
      load(3'd2, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
      for (int i = 1; i <= 8; i++) dot("prio", 4'h1, 1'b1, 1'b1, 1'b0);
      dot("prio dot9", 4'h0, 1'b0, 1'b0, 1'b0);

      // Sprite-0 flag window at x=5.
      clear();
      load(3'd0, 8'd5, 2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
      for (int i = 1; i <= 5; i++) dot("sp0 lead", 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 6; i <= 13; i++) dot("sp0 on", 4'h1, 1'b1, 1'b0, 1'b1);
      dot("sp0 dot14", 4'h0, 1'b0, 1'b0, 1'b0);

      // Same load then cleared: nothing visible.
      load(3'd0, 8'd5, 2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
      clear();
      for (int i = 1; i <= 14; i++) dot("sp0 clr", 4'h0, 1'b0, 1'b0, 1'b0);

      // Clear and load on the same edge: the load survives for its slot.
      slot = 3'd3; x_i = 8'd0; palette_i = 2'd1; pri_i = 1'b0; flip_x_i = 1'b0;
      sp0_i = 1'b0; data_i = 8'h80; load_attr = 1'b1; load_lo = 1'b1; clr_slots = 1'b1;
      tick();
      load_attr = 1'b0; load_lo = 1'b0; clr_slots = 1'b0;
      dot("clr+load", 4'h5, 1'b1, 1'b0, 1'b0);
      dot("clr+load 2", 4'h0, 1'b0, 1'b0, 1'b0);

      // Reset mid-line discards the sprite.
      clear();
      load(3'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
      for (int i = 1; i <= 3; i++) dot("pre rst", 4'h1, 1'b1, 1'b0, 1'b0);
      rst = 1'b0; active = 1'b1;
      tick();
      rst = 1'b1; active = 1'b0;
      chk_pix("mid rst", 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) dot("post rst", 4'h0, 1'b0, 1'b0, 1'b0);

      // ena low holds outputs and shift position (pattern 1010_0000).
      clear();
      load(3'd0, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'hA0, 8'h00);
      dot("ena dot1", 4'h5, 1'b1, 1'b0, 1'b0);
      ena = 1'b0; active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_pix("ena hold", 4'h5, 1'b1, 1'b0, 1'b0);
      end
      ena = 1'b1; active = 1'b0;
      dot("ena dot2", 4'h0, 1'b0, 1'b0, 1'b0);
      dot("ena dot3", 4'h5, 1'b1, 1'b0, 1'b0);
      dot("ena dot4", 4'h0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
